// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM state codes
// and the alignment rule used to reject an access before it touches storage.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lowAddr);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lowAddr[0];
            SIZE_WORD: bad = |lowAddr;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-to-memory request/response bundle; the control unit is the master.
interface mem_responder_if;

    logic        req;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (output req, addr, size, we, wdata,
                    input  rdata, ack, err, busy);

    modport slave  (input  req, addr, size, we, wdata,
                    output rdata, ack, err, busy);

endinterface

// File: rtl/mem_byte_array.sv
// Byte-wide storage seen as 32-bit words: one asynchronous word read port and
// one byte-enabled word write port. Contents are never cleared.
module mem_byte_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-3:0] rdIdx,
    output logic [31:0]       rdWord,
    input  logic [ADDR_W-3:0] wrIdx,
    input  logic [3:0]        wrBe,
    input  logic [31:0]       wrData
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wrBe[b]) mem[{wrIdx, 2'(b)}] <= wrData[8*b +: 8];
        end
    end

    assign rdWord = {mem[{rdIdx, 2'd3}], mem[{rdIdx, 2'd2}],
                     mem[{rdIdx, 2'd1}], mem[{rdIdx, 2'd0}]};

endmodule

// File: rtl/mem_responder.sv
// Stalling memory responder: captures one request, waits WAIT_CYCLES, then
// answers with a one-cycle ack (err on misalignment) and little-endian data.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);

    logic [1:0]        state, nextState;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] capAddr;
    logic [1:0]        capSize;
    logic              capWe;
    logic [31:0]       capWdata;

    logic [ADDR_W-1:0] selAddr;
    logic [1:0]        selSize;
    logic              selWe;
    logic              selBad;
    logic              capBad;
    logic [31:0]       rdWord;
    logic [3:0]        wrBe;
    logic [31:0]       rdataReg;
    logic              ackReg, errReg, busyReg;
    logic              unusedAddrHi;

    assign unusedAddrHi = &{1'b0, bus.addr[31:ADDR_W]};

    function automatic logic [31:0] steerRead(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lowAddr);
        logic [31:0] shifted;
        shifted = word >> {lowAddr, 3'b000};
        case (size)
            SIZE_BYTE: return {24'b0, shifted[7:0]};
            SIZE_HALF: return {16'b0, shifted[15:0]};
            default:   return word;
        endcase
    endfunction

    function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] lowAddr);
        case (size)
            SIZE_BYTE: return 4'b0001 << lowAddr;
            SIZE_HALF: return 4'b0011 << {lowAddr[1], 1'b0};
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] laneData(input logic [31:0] data, input logic [1:0] size);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

    // In IDLE the live bus is the request being captured this edge (matters when WAIT_CYCLES=0)
    assign selAddr = (state == ST_IDLE) ? bus.addr[ADDR_W-1:0] : capAddr;
    assign selSize = (state == ST_IDLE) ? bus.size : capSize;
    assign selWe   = (state == ST_IDLE) ? bus.we   : capWe;
    assign selBad  = isMisaligned(selSize, selAddr[1:0]);
    assign capBad  = isMisaligned(capSize, capAddr[1:0]);

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:   if (bus.req) nextState = HAS_WAIT ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (cnt == 4'd1) nextState = ST_ACCESS;
            ST_ACCESS: nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    // Write commits on the edge that leaves ACCESS, from the captured copy only
    assign wrBe = (state == ST_ACCESS && capWe && !capBad) ? byteEnable(capSize, capAddr[1:0]) : 4'b0000;

    mem_byte_array #(.ADDR_W(ADDR_W)) uArray (
        .clk    (clk),
        .rdIdx  (selAddr[ADDR_W-1:2]),
        .rdWord (rdWord),
        .wrIdx  (capAddr[ADDR_W-1:2]),
        .wrBe   (wrBe),
        .wrData (laneData(capWdata, capSize))
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            ackReg   <= 1'b0;
            errReg   <= 1'b0;
            busyReg  <= 1'b0;
            rdataReg <= 32'd0;
        end else begin
            state   <= nextState;
            busyReg <= (nextState != ST_IDLE);
            ackReg  <= (nextState == ST_ACCESS);
            errReg  <= (nextState == ST_ACCESS) && selBad;
            if (state == ST_IDLE && bus.req) cnt <= WAIT_INIT;
            else if (state == ST_WAIT)       cnt <= cnt - 4'd1;
            if (nextState == ST_ACCESS && !selWe && !selBad)
                rdataReg <= steerRead(rdWord, selSize, selAddr[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.req) begin
            capAddr  <= bus.addr[ADDR_W-1:0];
            capSize  <= bus.size;
            capWe    <= bus.we;
            capWdata <= bus.wdata;
        end
    end

    assign bus.rdata = rdataReg;
    assign bus.ack   = ackReg;
    assign bus.err   = errReg;
    assign bus.busy  = busyReg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with three wait states, one with none,
// sharing clock and reset; expected values are hand-computed constants.
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if busA ();
    mem_responder_if busB ();

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) dutA (.clk(clk), .reset(reset), .bus(busA));
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dutB (.clk(clk), .reset(reset), .bus(busB));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts on a negedge with the DUT idle; returns on a negedge with it idle again
    task automatic accA(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit scramble,
                        output logic [31:0] rd, output logic er, output int cyc);
        busA.we = we; busA.size = sz; busA.addr = a; busA.wdata = wd; busA.req = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (scramble && cyc == 1) begin
                busA.addr = 32'h20; busA.size = SIZE_BYTE; busA.wdata = 32'hFFFFFFFF;
            end
        end while (busA.ack !== 1'b1 && cyc < 20);
        rd = busA.rdata; er = busA.err;
        busA.req = 1'b0;
        @(negedge clk);
    endtask

    task automatic accB(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int cyc);
        busB.we = we; busB.size = sz; busB.addr = a; busB.wdata = wd; busB.req = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (busB.ack !== 1'b1 && cyc < 20);
        rd = busB.rdata; er = busB.err;
        busB.req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        logic [31:0] b2bData [3];
        b2bData[0] = 32'hA0A0A0A0;
        b2bData[1] = 32'hB1B1B1B1;
        b2bData[2] = 32'hC2C2C2C2;

        busA.req = 1'b0; busA.addr = '0; busA.size = SIZE_WORD; busA.we = 1'b0; busA.wdata = '0;
        busB.req = 1'b0; busB.addr = '0; busB.size = SIZE_WORD; busB.we = 1'b0; busB.wdata = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, busA.ack}, 32'd0);
        chk("rst_busy", {31'd0, busA.busy}, 32'd0);
        chk("rst_rdata", busA.rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset abandons an in-flight write
        accA(1'b1, SIZE_WORD, 32'h10, 32'h11223344, 1'b0, rd, er, cyc);
        chk("pre_sw_lat", cyc, 4);
        accA(1'b0, SIZE_WORD, 32'h10, 32'h0, 1'b0, rd, er, cyc);
        chk("pre_lw_data", rd, 32'h11223344);
        busA.we = 1'b1; busA.size = SIZE_WORD; busA.addr = 32'h10; busA.wdata = 32'hDEADBEEF;
        busA.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midwait_busy", {31'd0, busA.busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_ack", {31'd0, busA.ack}, 32'd0);
        chk("arst_busy", {31'd0, busA.busy}, 32'd0);
        chk("arst_rdata", busA.rdata, 32'd0);
        busA.req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_ack_after", {31'd0, busA.ack}, 32'd0);
        accA(1'b0, SIZE_WORD, 32'h10, 32'h0, 1'b0, rd, er, cyc);
        chk("abandon_lw", rd, 32'h11223344);

        // Word round trip with three wait states
        accA(1'b1, SIZE_WORD, 32'h20, 32'h12345678, 1'b0, rd, er, cyc);
        chk("sw20_lat", cyc, 4);
        chk("sw20_err", {31'd0, er}, 32'd0);
        accA(1'b0, SIZE_WORD, 32'h20, 32'h0, 1'b0, rd, er, cyc);
        chk("lw20_lat", cyc, 4);
        chk("lw20_data", rd, 32'h12345678);
        chk("lw20_err", {31'd0, er}, 32'd0);

        // Sub-word lanes
        accA(1'b1, SIZE_BYTE, 32'h21, 32'hFFFFFFAA, 1'b0, rd, er, cyc);
        accA(1'b1, SIZE_HALF, 32'h22, 32'hFFFFBEEF, 1'b0, rd, er, cyc);
        accA(1'b0, SIZE_WORD, 32'h20, 32'h0, 1'b0, rd, er, cyc);
        chk("lanes_lw", rd, 32'hBEEFAA78);
        accA(1'b0, SIZE_BYTE, 32'h23, 32'h0, 1'b0, rd, er, cyc);
        chk("lanes_lb", rd, 32'h000000BE);
        accA(1'b0, SIZE_HALF, 32'h20, 32'h0, 1'b0, rd, er, cyc);
        chk("lanes_lh", rd, 32'h0000AA78);

        // Misalignment and reserved size
        accA(1'b0, SIZE_WORD, 32'h22, 32'h0, 1'b0, rd, er, cyc);
        chk("mis_lw_err", {31'd0, er}, 32'd1);
        chk("mis_lw_lat", cyc, 4);
        chk("mis_lw_hold", rd, 32'h0000AA78);
        accA(1'b1, SIZE_WORD, 32'h30, 32'hCAFEF00D, 1'b0, rd, er, cyc);
        accA(1'b1, SIZE_HALF, 32'h31, 32'h00005555, 1'b0, rd, er, cyc);
        chk("mis_sh_err", {31'd0, er}, 32'd1);
        accA(1'b0, SIZE_WORD, 32'h30, 32'h0, 1'b0, rd, er, cyc);
        chk("mis_sh_mem", rd, 32'hCAFEF00D);
        accA(1'b1, SIZE_WORD, 32'h40, 32'h01020304, 1'b0, rd, er, cyc);
        accA(1'b1, SIZE_RSVD, 32'h40, 32'hFFFFFFFF, 1'b0, rd, er, cyc);
        chk("rsvd_err", {31'd0, er}, 32'd1);
        chk("rsvd_hold", rd, 32'hCAFEF00D);
        accA(1'b0, SIZE_WORD, 32'h40, 32'h0, 1'b0, rd, er, cyc);
        chk("rsvd_mem", rd, 32'h01020304);
        chk("good_err", {31'd0, er}, 32'd0);

        // Back-to-back reads with no wait states
        for (int i = 0; i < 3; i++) begin
            accB(1'b1, SIZE_WORD, 32'(4 * i), b2bData[i], rd, er, cyc);
            chk("b_sw_lat", cyc, 1);
        end
        busB.we = 1'b0; busB.size = SIZE_WORD; busB.addr = 32'h0; busB.req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ack_c%0d", k), {31'd0, busB.ack}, {31'd0, k[0]});
            if (k[0]) begin
                chk($sformatf("b2b_data_c%0d", k), busB.rdata, b2bData[(k - 1) / 2]);
                if (k < 5) busB.addr = 32'(2 * (k + 1));
            end
        end
        busB.req = 1'b0;
        @(negedge clk);

        // Address wrap and capture stability
        accA(1'b1, SIZE_WORD, 32'h1FC, 32'h55AA33CC, 1'b0, rd, er, cyc);
        chk("wrap_sw_err", {31'd0, er}, 32'd0);
        accA(1'b0, SIZE_WORD, 32'hFC, 32'h0, 1'b1, rd, er, cyc);
        chk("wrap_lw_data", rd, 32'h55AA33CC);
        chk("wrap_lw_lat", cyc, 4);
        accA(1'b0, SIZE_WORD, 32'h20, 32'h0, 1'b0, rd, er, cyc);
        chk("stable_lw20", rd, 32'hBEEFAA78);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
